// File: rtl/axi_pkg.sv
// Shared AXI4 read-channel definitions: burst/response encodings, responder
// FSM states and the latched AR request record.
package axi_pkg;

   localparam int ID_W   = 12;
   localparam int ADDR_W = 32;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      RESP
   } state_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
   } ar_req_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI4 burst address stepper and burst-legality check, shared
// by the read responder and the bridge slave logic.
module axi_burst_addr_gen
   import axi_pkg::*;
(
   input  ar_req_t           req,
   input  logic [ADDR_W-1:0] cur_addr,
   output logic              err,
   output logic [ADDR_W-1:0] next_addr
);

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   logic [ADDR_W-1:0] size_bytes;
   logic [ADDR_W-1:0] step_bytes;
   logic [ADDR_W-1:0] total_bytes;
   logic [ADDR_W-1:0] wrap_lower;
   logic [ADDR_W-1:0] wrap_next;
   logic              wrap_len_ok;

   always_comb begin
      size_bytes  = ONE << req.size;
      wrap_len_ok = (req.len == 8'd1) || (req.len == 8'd3) ||
                    (req.len == 8'd7) || (req.len == 8'd15);
      err = (req.size > 3'd3) || (req.burst == 2'b11) ||
            ((req.burst == BURST_WRAP) &&
             (!wrap_len_ok || ((req.addr & (size_bytes - ONE)) != '0)));

      // Illegal bursts still walk memory as INCR with 8-byte beats.
      step_bytes  = ONE << (err ? 3'd3 : req.size);
      total_bytes = step_bytes * ADDR_W'({1'b0, req.len} + 9'd1);
      wrap_lower  = cur_addr & ~(total_bytes - ONE);
      wrap_next   = cur_addr + step_bytes;
      if (wrap_next == wrap_lower + total_bytes) begin
         wrap_next = wrap_lower;
      end

      if (err || (req.burst == BURST_INCR)) begin
         next_addr = (cur_addr & ~(step_bytes - ONE)) + step_bytes;
      end else if (req.burst == BURST_WRAP) begin
         next_addr = wrap_next;
      end else begin
         next_addr = cur_addr;
      end
   end

endmodule

// File: rtl/axi_rd_burst_responder.sv
// AXI4 read slave with one outstanding burst: accepts AR, reads a 1-cycle
// latency local memory once per beat and returns R beats (2 cycles/beat).
module axi_rd_burst_responder
   import axi_pkg::*;
#(
   parameter int IDW = ID_W,
   parameter int AW  = ADDR_W,
   parameter int DW  = 64
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic [IDW-1:0] s_axi_arid,
   input  logic [AW-1:0]  s_axi_araddr,
   input  logic [7:0]     s_axi_arlen,
   input  logic [2:0]     s_axi_arsize,
   input  logic [1:0]     s_axi_arburst,
   input  logic           s_axi_arvalid,
   output logic           s_axi_arready,
   output logic [IDW-1:0] s_axi_rid,
   output logic [DW-1:0]  s_axi_rdata,
   output logic [1:0]     s_axi_rresp,
   output logic           s_axi_rlast,
   output logic           s_axi_rvalid,
   input  logic           s_axi_rready,
   output logic           mem_ren,
   output logic [AW-1:0]  mem_addr,
   input  logic [DW-1:0]  mem_rdata
);

   state_t         state_q, state_d;
   ar_req_t        req_q, req_d;
   logic [AW-1:0]  cur_addr_q, cur_addr_d;
   logic [AW-1:0]  mem_addr_q, mem_addr_d;
   logic [7:0]     beat_cnt_q, beat_cnt_d;
   logic           arready_q, arready_d;
   logic           rvalid_q, rvalid_d;
   logic           rlast_q, rlast_d;
   logic [1:0]     rresp_q, rresp_d;
   logic [IDW-1:0] rid_q, rid_d;
   logic           mem_ren_q, mem_ren_d;
   logic           first_q, first_d;
   logic [DW-1:0]  rdata_q, rdata_d;
   logic [DW-1:0]  beat_data;
   logic [AW-1:0]  next_addr;
   logic           burst_err;

   axi_burst_addr_gen u_addr_gen (
      .req       (req_q),
      .cur_addr  (cur_addr_q),
      .err       (burst_err),
      .next_addr (next_addr)
   );

   assign beat_data = burst_err ? '0 : mem_rdata;

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      cur_addr_d = cur_addr_q;
      mem_addr_d = mem_addr_q;
      beat_cnt_d = beat_cnt_q;
      arready_d  = arready_q;
      rvalid_d   = rvalid_q;
      rlast_d    = rlast_q;
      rresp_d    = rresp_q;
      rid_d      = rid_q;
      mem_ren_d  = mem_ren_q;
      first_d    = 1'b0;
      rdata_d    = first_q ? beat_data : rdata_q;

      unique case (state_q)
         IDLE: begin
            arready_d = 1'b1;
            if (s_axi_arvalid && arready_q) begin
               req_d = '{id: s_axi_arid, addr: s_axi_araddr, len: s_axi_arlen,
                         size: s_axi_arsize, burst: s_axi_arburst};
               cur_addr_d = s_axi_araddr;
               beat_cnt_d = '0;
               arready_d  = 1'b0;
               mem_ren_d  = 1'b1;
               mem_addr_d = {s_axi_araddr[AW-1:3], 3'b000};
               state_d    = FETCH;
            end
         end
         FETCH: begin
            mem_ren_d = 1'b0;
            rvalid_d  = 1'b1;
            rlast_d   = (beat_cnt_q == req_q.len);
            rresp_d   = burst_err ? RESP_SLVERR : RESP_OKAY;
            rid_d     = req_q.id;
            first_d   = 1'b1;
            state_d   = RESP;
         end
         RESP: begin
            if (s_axi_rready) begin
               rvalid_d = 1'b0;
               rlast_d  = 1'b0;
               if (rlast_q) begin
                  arready_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  cur_addr_d = next_addr;
                  beat_cnt_d = beat_cnt_q + 8'd1;
                  mem_ren_d  = 1'b1;
                  mem_addr_d = {next_addr[AW-1:3], 3'b000};
                  state_d    = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         req_q      <= '0;
         cur_addr_q <= '0;
         mem_addr_q <= '0;
         beat_cnt_q <= '0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rlast_q    <= 1'b0;
         rresp_q    <= RESP_OKAY;
         rid_q      <= '0;
         mem_ren_q  <= 1'b0;
         first_q    <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         cur_addr_q <= cur_addr_d;
         mem_addr_q <= mem_addr_d;
         beat_cnt_q <= beat_cnt_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rlast_q    <= rlast_d;
         rresp_q    <= rresp_d;
         rid_q      <= rid_d;
         mem_ren_q  <= mem_ren_d;
         first_q    <= first_d;
         rdata_q    <= rdata_d;
      end
   end

   // NOTE: memory data only arrives in the RESP entry cycle, so rdata passes
   // mem_rdata straight through then and replays the captured copy while stalled.
   assign s_axi_rdata   = first_q ? beat_data : rdata_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rlast   = rlast_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rid     = rid_q;
   assign mem_ren       = mem_ren_q;
   assign mem_addr      = mem_addr_q;

endmodule

// File: tb/tb_axi_rd_burst_responder.sv
// Self-checking bench for axi_rd_burst_responder: directed table vectors,
// backpressure and mid-burst reset sequences, then randomized bursts.
module tb_axi_rd_burst_responder;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [11:0] arid = '0;
   logic [31:0] araddr = '0;
   logic [7:0]  arlen = '0;
   logic [2:0]  arsize = '0;
   logic [1:0]  arburst = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [11:0] rid;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready = 1'b0;
   logic        mem_ren;
   logic [31:0] mem_addr;
   logic [63:0] mem_rdata = '0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   logic        exp_err;

   axi_rd_burst_responder #(.IDW(12), .AW(32), .DW(64)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .s_axi_arid    (arid),
      .s_axi_araddr  (araddr),
      .s_axi_arlen   (arlen),
      .s_axi_arsize  (arsize),
      .s_axi_arburst (arburst),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rid     (rid),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rlast   (rlast),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .mem_ren       (mem_ren),
      .mem_addr      (mem_addr),
      .mem_rdata     (mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] pattern(input logic [31:0] a);
      return {a ^ 32'h5A5A_0F0F, ~a};
   endfunction

   // Memory returns the addressed word the cycle after mem_ren, junk otherwise.
   always @(posedge clk) begin
      if (mem_ren) mem_rdata <= pattern(mem_addr);
      else         mem_rdata <= {$urandom, $urandom};
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_err(input logic [31:0] a, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
      logic len_ok;
      len_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
      if (size > 3 || burst == 2'b11) return 1'b1;
      if (burst == 2'b10 && (!len_ok || (a % (32'd1 << size)) != 0)) return 1'b1;
      return 1'b0;
   endfunction

   // Memory address of beat i computed directly from the start address.
   function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst,
                                              input logic err, input int i);
      logic [31:0] bytes, total, lower, b;
      bytes = 32'd1 << (err ? 3'd3 : size);
      total = bytes * (32'(len) + 1);
      if (!err && burst == 2'b00) b = a;
      else if (!err && burst == 2'b10) begin
         lower = a - (a % total);
         b = lower + ((a - lower) + 32'(i) * bytes) % total;
      end else b = (i == 0) ? a : (a - (a % bytes)) + 32'(i) * bytes;
      return {b[31:3], 3'b000};
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_arready"}, arready, 0);
      check({tag, "_rvalid"}, rvalid, 0);
      check({tag, "_rlast"}, rlast, 0);
      check({tag, "_rresp"}, rresp, 0);
      check({tag, "_rid"}, rid, 0);
      check({tag, "_rdata"}, rdata, 0);
      check({tag, "_mem_ren"}, mem_ren, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
   endtask

   // Issues one AR at a negedge and checks every R beat against exp_q/exp_err.
   task automatic run_burst(input logic [11:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int stall_beat, input int stall_len, input bit rnd_ready);
      int beat, fetches, cyc, stall_cnt;
      bit done, first_seen;
      logic [63:0] exp_data;
      cyc = 0;
      while (!arready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("arready_idle", arready, 1);
      arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      beat = 0; fetches = 0; cyc = 0; stall_cnt = 0; done = 0; first_seen = 0;
      while (!done && cyc < 400) begin
         check("arready_busy", arready, 0);
         if (mem_ren) begin
            check("fetch_order", fetches, beat);
            if (fetches < exp_q.size()) check("mem_addr", mem_addr, exp_q[fetches]);
            fetches++;
         end
         if (rvalid) begin
            if (!first_seen) begin
               check("first_latency", cyc, 1);
               first_seen = 1;
            end
            exp_data = (exp_err || beat >= exp_q.size()) ? 64'd0 : pattern(exp_q[beat]);
            check("rid", rid, id);
            check("rdata", rdata, exp_data);
            check("rresp", rresp, exp_err ? 2'b10 : 2'b00);
            check("rlast", rlast, beat == int'(len));
            if (beat == stall_beat && stall_cnt < stall_len) begin
               rready = 1'b0;
               stall_cnt++;
            end else if (rnd_ready && $urandom_range(0, 2) == 0) rready = 1'b0;
            else rready = 1'b1;
            if (rready) begin
               if (beat == int'(len)) done = 1;
               beat++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      rready = 1'b0;
      check("burst_done", done, 1);
      check("beat_count", beat, int'(len) + 1);
      check("fetch_count", fetches, int'(len) + 1);
      check("arready_after", arready, 1);
      check("rvalid_after", rvalid, 0);
   endtask

   typedef struct {
      logic [11:0]      id;
      logic [31:0]      addr;
      logic [7:0]       len;
      logic [2:0]       size;
      logic [1:0]       burst;
      logic [3:0][31:0] addrs;
      logic             err;
      int               stall_beat;
      int               stall_len;
   } vec_t;

   vec_t tbl [7];

   task automatic run_vec(input int t);
      exp_q.delete();
      for (int i = 0; i <= int'(tbl[t].len); i++) exp_q.push_back(tbl[t].addrs[i]);
      exp_err = tbl[t].err;
      run_burst(tbl[t].id, tbl[t].addr, tbl[t].len, tbl[t].size, tbl[t].burst,
                tbl[t].stall_beat, tbl[t].stall_len, 1'b0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen, cyc;
      logic [31:0] a;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;

      tbl[0] = '{12'h0A1, 32'h100, 8'd3, 3'd3, 2'b01, {32'h118, 32'h110, 32'h108, 32'h100}, 1'b0, -1, 0};
      tbl[1] = '{12'h0B2, 32'h38,  8'd3, 3'd3, 2'b10, {32'h30,  32'h28,  32'h20,  32'h38},  1'b0, -1, 0};
      tbl[2] = '{12'h0C3, 32'h103, 8'd2, 3'd2, 2'b01, {32'h0,   32'h108, 32'h100, 32'h100}, 1'b0, -1, 0};
      tbl[3] = '{12'h0D4, 32'h200, 8'd1, 3'd3, 2'b11, {32'h0,   32'h0,   32'h208, 32'h200}, 1'b1, -1, 0};
      tbl[4] = '{12'h0E5, 32'h40,  8'd2, 3'd3, 2'b10, {32'h0,   32'h50,  32'h48,  32'h40},  1'b1, -1, 0};
      tbl[5] = '{12'h0F6, 32'h80,  8'd2, 3'd3, 2'b00, {32'h0,   32'h80,  32'h80,  32'h80},  1'b0, -1, 0};
      tbl[6] = '{12'h7A7, 32'h100, 8'd3, 3'd3, 2'b01, {32'h118, 32'h110, 32'h108, 32'h100}, 1'b0, 1, 5};

      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      resetn = 1'b1;
      @(negedge clk);

      for (int t = 0; t < 7; t++) run_vec(t);

      // Reset asserted while beat 2 of an 8-beat burst is being presented.
      arid = 12'h321; araddr = 32'h1000; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01;
      arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      rready = 1'b1;
      seen = 0; cyc = 0;
      while (seen < 2 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (rvalid) seen++;
      end
      check("midreset_reached_beat2", seen, 2);
      rready = 1'b0;
      resetn = 1'b0;
      #1;
      check_reset_vals("midreset");
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("post_reset_arready", arready, 1);
      run_vec(0);

      for (int n = 0; n < 40; n++) begin
         burst = 2'($urandom_range(0, 3));
         size  = 3'($urandom_range(0, 4));
         len   = (burst == 2'b10 && $urandom_range(0, 3) != 0) ?
                 8'((2 << $urandom_range(0, 3)) - 1) : 8'($urandom_range(0, 15));
         a     = (n % 8 == 0) ? 32'hFFFF_FFE0 + 32'($urandom_range(0, 31)) : $urandom;
         if (burst == 2'b10 && size <= 3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << size) - 1);
         exp_err = model_err(a, len, size, burst);
         exp_q.delete();
         for (int i = 0; i <= int'(len); i++) exp_q.push_back(model_addr(a, len, size, burst, exp_err, i));
         run_burst(12'($urandom_range(0, 4095)), a, len, size, burst, -1, 0, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_rd_burst_responder.md
Name: axi_rd_burst_responder

Overview:
- Slave-side AXI4 read responder directly downstream of the read-channel master bridge.
- Consumes the AR stream (araddr/arlen/arsize/arburst/arvalid) and walks the burst address sequence.
- Reads a local synchronous memory with 1-cycle latency and returns R beats with rdata/rlast/rresp/rid.
- Supports one outstanding burst.

Parameters:
IDW, 12, transaction ID width
AW, 32, address width
DW, 64, data width in bits; fixed at 64 (8-byte beats)

Ports:
clk  in  1  global clock
resetn  in  1  asynchronous active-low reset
s_axi_arid  in  IDW  read transaction ID
s_axi_araddr  in  AW  burst start byte address
s_axi_arlen  in  8  beats minus 1
s_axi_arsize  in  3  log2 bytes per beat
s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
s_axi_arvalid  in  1  address valid
s_axi_arready  out  1  address accepted
s_axi_rid  out  IDW  echoed ID
s_axi_rdata  out  DW  read data
s_axi_rresp  out  2  00 OKAY, 10 SLVERR
s_axi_rlast  out  1  final beat of burst
s_axi_rvalid  out  1  data valid
s_axi_rready  in  1  master ready
mem_ren  out  1  memory read strobe
mem_addr  out  AW  8-byte-aligned memory address
mem_rdata  in  DW  memory data, valid the cycle after mem_ren

Behaviour:
- Reset: one clock, clk. resetn is asynchronous and active-low.
- Reset values: arready=0, rvalid=0, rlast=0, rresp=00, rid=0, rdata=0, mem_ren=0, mem_addr=0, FSM=IDLE, beat counter=0.
- A reset assertion mid-burst abandons the burst immediately. No rlast is emitted.

FSM states: IDLE, FETCH, RESP.
- IDLE: arready=1.
  - On arvalid&arready, latch id/addr/len/size/burst.
  - Compute the error flag.
  - Clear the beat counter and go to FETCH.
- FETCH: mem_ren=1 for exactly one cycle.
  - mem_addr = {cur_addr[AW-1:3],3'b000}.
  - Go to RESP.
- RESP, entry cycle: rdata is captured from mem_rdata. It is forced to 0 when the error flag is set.
- RESP: rvalid=1 and is held stable until rready.
  - rlast=1 when beat counter == len.
  - On rvalid&rready with rlast=1: go to IDLE.
  - On rvalid&rready with rlast=0: advance cur_addr, increment the counter, go to FETCH.
- Throughput: 2 cycles per beat with rready tied high.
- First-beat latency: rvalid rises 2 cycles after the AR handshake cycle.
- arready is 0 outside IDLE. A new AR is accepted only in the cycle after the final R handshake.

Error flag (rresp=10 on every beat of the burst; the full len+1 beats are still returned):
- arsize>3
- arburst=11
- WRAP with arlen not in {1,3,7,15}
- WRAP with araddr not aligned to the beat size

Address arithmetic (bytes = 1<<size, total = bytes*(len+1)):
- FIXED: cur_addr is constant.
- INCR: next = (cur_addr & ~(bytes-1)) + bytes. Only the first beat may be unaligned. Wraps modulo 2^AW with no error.
- WRAP: lower = cur_addr & ~(total-1). next = cur_addr+bytes. If next == lower+total, then next = lower.
- For erroneous bursts, the address still advances as INCR with size clamped to 3. The memory is still read; its data is discarded.
- rid echoes the latched arid on every beat.

Decomposition:
- Shared package axi_pkg:
  - burst type constants BURST_FIXED/INCR/WRAP
  - RESP_OKAY/RESP_SLVERR
  - state enum
  - AR request struct (id, addr, len, size, burst)
- Sub-module axi_burst_addr_gen: combinational next-address and error-flag logic, so the bridge slave logic can reuse it.

Test Plan:
- INCR: araddr=0x100, arlen=3, arsize=3, rready=1.
  - mem_addr sequence 0x100, 0x108, 0x110, 0x118.
  - 4 beats, rlast on beat 4, rresp=00.
  - First rvalid 2 cycles after the AR handshake.
- WRAP: araddr=0x38, arlen=3, arsize=3.
  - mem_addr sequence 0x38, 0x20, 0x28, 0x30.
  - rlast on the 4th beat.
- Unaligned INCR: araddr=0x103, arsize=2, arlen=2.
  - mem_addr 0x100, 0x100, 0x108 (cur_addr 0x103, 0x104, 0x108).
- Errors:
  - arburst=11, arlen=1: 2 beats, rresp=10, rdata=0.
  - WRAP with arlen=2: 3 beats, all SLVERR.
- Backpressure: rready held low for 5 cycles on beat 2.
  - rvalid, rdata, rlast and rid stay stable.
  - No extra mem_ren.
  - arready stays 0 until after the final beat.
- Reset mid-burst: resetn pulled low during beat 2 of an arlen=7 burst.
  - All outputs immediately return to reset values.
  - After release, arready=1 and a fresh burst completes normally.
